// File: rtl/spi_pkg.sv
// Shared types and limits for the spi_slave_n SPI slave.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } spi_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 3;
    localparam int DATA_W_MIN      = 4;
    localparam int DATA_W_MAX      = 32;

    function automatic bit cfg_legal(input int data_w, input int sync_stages);
        return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
               (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/spi_slave_n_if.sv
// SPI pins plus the parallel tx/rx handshake of spi_slave_n.
interface spi_slave_n_if #(
    parameter int DATA_W = 8
) ();
    logic              ss;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ack;
    logic              done;
    logic              busy;

    modport slave (
        input  ss, sck, mosi, tx_data, tx_valid, rx_ack,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, done, busy
    );

    modport master (
        output ss, sck, mosi, tx_data, tx_valid, rx_ack,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, done, busy
    );
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input with rise/fall pulses
// derived from the synchronised value.
module spi_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_slave_n.sv
// SPI slave oversampled by clk: sync'd ss/sck/mosi, holding register for tx, rx word latch.
// Define SPI_SLAVE_N_OVERRUN_EN to add the sticky overrun output.
module spi_slave_n
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef SPI_SLAVE_N_OVERRUN_EN
    output logic overrun,
`endif
    spi_slave_n_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    if (!cfg_legal(DATA_W, SYNC_STAGES)) begin : g_cfg_check
        $error("spi_slave_n: DATA_W or SYNC_STAGES out of range");
    end

    logic ss_s, ss_rise, ss_fall;
    logic sck_s, sck_rise, sck_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .d_i(bus.ss), .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck_sync (
        .clk(clk), .rst(rst), .d_i(bus.sck), .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) mosi_sync_q <= '0;
        else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
    logic              tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
    logic              done_q, done_d, miso_q, miso_d;

    logic sck_edge, lead, trail, sample_edge, shift_edge, wrap, load_tx, tx_bit;
    logic [DATA_W-1:0] rx_next, tx_shifted, tx_fill;

    // Leading edge = sck moving away from its idle level.
    assign sck_edge    = sck_rise | sck_fall;
    assign lead        = sck_edge & (sck_s != CPOL);
    assign trail       = sck_edge & (sck_s == CPOL);
    assign sample_edge = (state_q == XFER) & (CPHA ? trail : lead);
    assign shift_edge  = (state_q == XFER) & (CPHA ? lead : trail);
    assign wrap        = sample_edge & (cnt_q == LAST_BIT);
    assign load_tx     = (state_q == LOAD) | wrap;

    assign rx_next    = MSB_FIRST ? {rx_sr_q[DATA_W-2:0], mosi_s} : {mosi_s, rx_sr_q[DATA_W-1:1]};
    assign tx_bit     = MSB_FIRST ? tx_sr_q[DATA_W-1] : tx_sr_q[0];
    assign tx_shifted = MSB_FIRST ? {tx_sr_q[DATA_W-2:0], 1'b0} : {1'b0, tx_sr_q[DATA_W-1:1]};
    assign tx_fill    = tx_ready_q ? '0 : hold_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        hold_d     = hold_q;
        rx_data_d  = rx_data_q;
        tx_ready_d = tx_ready_q;
        rx_valid_d = rx_valid_q;
        done_d     = 1'b0;
        miso_d     = miso_q;

        unique case (state_q)
            IDLE:    if (ss_fall) state_d = LOAD;
            LOAD:    state_d = ss_rise ? IDLE : XFER;
            XFER:    if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == LOAD) begin
            cnt_d   = '0;
            rx_sr_d = '0;
            miso_d  = 1'b0;
        end

        // CPHA=0 already presents bit 0 from LOAD/wrap, so the trailing edge right after a wrap must not shift.
        if (shift_edge) begin
            if (CPHA) begin
                miso_d  = tx_bit;
                tx_sr_d = tx_shifted;
            end else if (cnt_q != '0) begin
                tx_sr_d = tx_shifted;
            end
        end

        if (sample_edge) begin
            rx_sr_d = rx_next;
            cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        end

        if (wrap) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            done_d     = 1'b1;
        end else if (bus.rx_ack) begin
            rx_valid_d = 1'b0;
        end

        if (load_tx) begin
            tx_sr_d    = tx_fill;
            tx_ready_d = 1'b1;
        end

        if (bus.tx_valid && tx_ready_q) begin
            hold_d     = bus.tx_data;
            tx_ready_d = 1'b0;
        end

        if (ss_rise) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            hold_q     <= '0;
            rx_data_q  <= '0;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            hold_q     <= hold_d;
            rx_data_q  <= rx_data_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            miso_q     <= miso_d;
        end
    end

`ifdef SPI_SLAVE_N_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (wrap && rx_valid_q && !bus.rx_ack) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`endif

    assign bus.miso_oe  = ~ss_s;
    assign bus.miso     = ~ss_s & (CPHA ? miso_q : tx_bit);
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave_n.sv
// Directed bench for spi_slave_n: five instances cover modes 0..3, LSB/MSB order and a 16-bit word.
`timescale 1ns/1ps
module tb_spi_slave_n;
    localparam int CLK_HALF = 5;
    localparam int HALF     = 60;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #CLK_HALF clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int sel = 0;
    logic m_ss = 1'b1, m_act = 1'b0, m_mosi = 1'b0;
    logic [31:0] m_tx_data = '0;
    logic m_tx_valid = 1'b0, m_rx_ack = 1'b0;

    int cfg_cpha [5] = '{0, 1, 0, 1, 0};
    int cfg_msb  [5] = '{1, 0, 0, 0, 1};
    int cfg_w    [5] = '{8, 8, 8, 8, 16};
    int cur_cpha = 0, cur_msb = 1, cur_w = 8;

    spi_slave_n_if #(.DATA_W(8))  b0 ();
    spi_slave_n_if #(.DATA_W(8))  b1 ();
    spi_slave_n_if #(.DATA_W(8))  b2 ();
    spi_slave_n_if #(.DATA_W(8))  b3 ();
    spi_slave_n_if #(.DATA_W(16)) b4 ();

    assign b0.ss = (sel == 0) ? m_ss : 1'b1;
    assign b1.ss = (sel == 1) ? m_ss : 1'b1;
    assign b2.ss = (sel == 2) ? m_ss : 1'b1;
    assign b3.ss = (sel == 3) ? m_ss : 1'b1;
    assign b4.ss = (sel == 4) ? m_ss : 1'b1;
    assign b0.sck = (sel == 0) & m_act;
    assign b1.sck = (sel == 1) & m_act;
    assign b2.sck = ~((sel == 2) & m_act);
    assign b3.sck = ~((sel == 3) & m_act);
    assign b4.sck = (sel == 4) & m_act;
    assign b0.mosi = m_mosi;
    assign b1.mosi = m_mosi;
    assign b2.mosi = m_mosi;
    assign b3.mosi = m_mosi;
    assign b4.mosi = m_mosi;
    assign b0.tx_data = m_tx_data[7:0];
    assign b1.tx_data = m_tx_data[7:0];
    assign b2.tx_data = m_tx_data[7:0];
    assign b3.tx_data = m_tx_data[7:0];
    assign b4.tx_data = m_tx_data[15:0];
    assign b0.tx_valid = (sel == 0) & m_tx_valid;
    assign b1.tx_valid = (sel == 1) & m_tx_valid;
    assign b2.tx_valid = (sel == 2) & m_tx_valid;
    assign b3.tx_valid = (sel == 3) & m_tx_valid;
    assign b4.tx_valid = (sel == 4) & m_tx_valid;
    assign b0.rx_ack = (sel == 0) & m_rx_ack;
    assign b1.rx_ack = (sel == 1) & m_rx_ack;
    assign b2.rx_ack = (sel == 2) & m_rx_ack;
    assign b3.rx_ack = (sel == 3) & m_rx_ack;
    assign b4.rx_ack = (sel == 4) & m_rx_ack;

    wire [4:0] ovr;
`ifndef SPI_SLAVE_N_OVERRUN_EN
    assign ovr = '0;
`endif

    spi_slave_n #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst),
`ifdef SPI_SLAVE_N_OVERRUN_EN
        .overrun(ovr[0]),
`endif
        .bus(b0));
    spi_slave_n #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef SPI_SLAVE_N_OVERRUN_EN
        .overrun(ovr[1]),
`endif
        .bus(b1));
    spi_slave_n #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst),
`ifdef SPI_SLAVE_N_OVERRUN_EN
        .overrun(ovr[2]),
`endif
        .bus(b2));
    spi_slave_n #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(3)) u_dut3 (
        .clk(clk), .rst(rst),
`ifdef SPI_SLAVE_N_OVERRUN_EN
        .overrun(ovr[3]),
`endif
        .bus(b3));
    spi_slave_n #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut4 (
        .clk(clk), .rst(rst),
`ifdef SPI_SLAVE_N_OVERRUN_EN
        .overrun(ovr[4]),
`endif
        .bus(b4));

    logic miso_sel, oe_sel, rx_valid_sel, done_sel, tx_ready_sel, busy_sel, ovr_sel;
    logic [31:0] rx_data_sel;

    always_comb begin
        miso_sel = 1'b0; oe_sel = 1'b0; rx_valid_sel = 1'b0; done_sel = 1'b0;
        tx_ready_sel = 1'b0; busy_sel = 1'b0; rx_data_sel = '0;
        ovr_sel = ovr[sel];
        case (sel)
            0: begin miso_sel = b0.miso; oe_sel = b0.miso_oe; rx_valid_sel = b0.rx_valid; done_sel = b0.done;
                     tx_ready_sel = b0.tx_ready; busy_sel = b0.busy; rx_data_sel = 32'(b0.rx_data); end
            1: begin miso_sel = b1.miso; oe_sel = b1.miso_oe; rx_valid_sel = b1.rx_valid; done_sel = b1.done;
                     tx_ready_sel = b1.tx_ready; busy_sel = b1.busy; rx_data_sel = 32'(b1.rx_data); end
            2: begin miso_sel = b2.miso; oe_sel = b2.miso_oe; rx_valid_sel = b2.rx_valid; done_sel = b2.done;
                     tx_ready_sel = b2.tx_ready; busy_sel = b2.busy; rx_data_sel = 32'(b2.rx_data); end
            3: begin miso_sel = b3.miso; oe_sel = b3.miso_oe; rx_valid_sel = b3.rx_valid; done_sel = b3.done;
                     tx_ready_sel = b3.tx_ready; busy_sel = b3.busy; rx_data_sel = 32'(b3.rx_data); end
            default: begin miso_sel = b4.miso; oe_sel = b4.miso_oe; rx_valid_sel = b4.rx_valid; done_sel = b4.done;
                     tx_ready_sel = b4.tx_ready; busy_sel = b4.busy; rx_data_sel = 32'(b4.rx_data); end
        endcase
    end

    // Every done-high cycle logs rx_data; tx_ready rising edges are counted.
    logic [31:0] rxq[$];
    int   rdy_rises = 0;
    logic rdy_prev  = 1'b1;
    always @(negedge clk) begin
        if (done_sel) rxq.push_back(rx_data_sel);
        if (tx_ready_sel && !rdy_prev) rdy_rises <= rdy_rises + 1;
        rdy_prev <= tx_ready_sel;
    end

    task automatic set_sel(input int idx);
        sel = idx; cur_cpha = cfg_cpha[idx]; cur_msb = cfg_msb[idx]; cur_w = cfg_w[idx];
        repeat (8) @(negedge clk);
    endtask

    task automatic tx_push(input logic [31:0] v);
        int n = 0;
        @(negedge clk);
        while (!tx_ready_sel && n < 1000) begin @(negedge clk); n++; end
        if (!tx_ready_sel) begin
            checks++; failures++;
            $display("FAIL tx_push_timeout tx_ready=%b required=1", tx_ready_sel);
        end
        m_tx_data = v; m_tx_valid = 1'b1;
        @(negedge clk);
        m_tx_valid = 1'b0;
    endtask

    task automatic rx_ack_pulse();
        @(negedge clk); m_rx_ack = 1'b1;
        @(negedge clk); m_rx_ack = 1'b0;
    endtask

    task automatic ss_low();
        @(negedge clk); m_ss = 1'b0; #(2*HALF);
    endtask

    task automatic ss_high();
        #HALF; m_ss = 1'b1; #(12*2*CLK_HALF);
    endtask

    task automatic spi_word(input logic [31:0] tx, input int nbits, output logic [31:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = (cur_msb != 0) ? cur_w - 1 - i : i;
            if (cur_cpha == 0) begin
                m_mosi = tx[b]; #HALF;
                m_act = 1'b1; got[b] = miso_sel; #HALF;
                m_act = 1'b0;
            end else begin
                m_act = 1'b1; m_mosi = tx[b]; #HALF;
                m_act = 1'b0; got[b] = miso_sel; #HALF;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; m_ss = 1'b1; m_act = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_ready_sel !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b required=1", tx_ready_sel); end
        checks++; if (rx_valid_sel !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b required=0", rx_valid_sel); end
        checks++; if (busy_sel !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy_sel); end
        checks++; if ({miso_sel, oe_sel, done_sel} !== 3'b000) begin failures++; $display("FAIL reset_miso_oe_done got=%b required=000", {miso_sel, oe_sel, done_sel}); end
        checks++; if (rx_data_sel !== 32'h0) begin failures++; $display("FAIL reset_rx_data got=%h required=0", rx_data_sel); end
    endtask

    task automatic test_mode0();
        logic [31:0] got;
        int base;
        set_sel(0);
        base = rxq.size();
        tx_push(32'h3C);
        ss_low();
        checks++; if ({busy_sel, oe_sel} !== 2'b11) begin failures++; $display("FAIL mode0_busy_oe got=%b required=11", {busy_sel, oe_sel}); end
        spi_word(32'hA5, 8, got);
        ss_high();
        checks++; if (rx_data_sel !== 32'hA5) begin failures++; $display("FAIL mode0_rx got=%h required=a5", rx_data_sel); end
        checks++; if (got !== 32'h3C) begin failures++; $display("FAIL mode0_miso got=%h required=3c", got); end
        checks++; if (rxq.size() - base !== 1) begin failures++; $display("FAIL mode0_done_count got=%0d required=1", rxq.size() - base); end
        checks++; if ({rx_valid_sel, busy_sel, oe_sel, miso_sel} !== 4'b1000) begin failures++; $display("FAIL mode0_after got=%b required=1000", {rx_valid_sel, busy_sel, oe_sel, miso_sel}); end
        rx_ack_pulse();
        @(negedge clk);
        checks++; if (rx_valid_sel !== 1'b0) begin failures++; $display("FAIL mode0_ack got=%b required=0", rx_valid_sel); end
    endtask

    task automatic test_modes_lsb();
        logic [31:0] got;
        for (int m = 1; m <= 3; m++) begin
            set_sel(m);
            tx_push(32'h81);
            ss_low(); spi_word(32'h81, 8, got); ss_high();
            checks++; if (rx_data_sel !== 32'h81) begin failures++; $display("FAIL mode%0d_rx81 got=%h required=81", m, rx_data_sel); end
            checks++; if (got !== 32'h81) begin failures++; $display("FAIL mode%0d_miso81 got=%h required=81", m, got); end
            tx_push(32'hC6);
            ss_low(); spi_word(32'h35, 8, got); ss_high();
            checks++; if (rx_data_sel !== 32'h35) begin failures++; $display("FAIL mode%0d_rx35 got=%h required=35", m, rx_data_sel); end
            checks++; if (got !== 32'hC6) begin failures++; $display("FAIL mode%0d_misoC6 got=%h required=c6", m, got); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mw [3] = '{32'h11, 32'h22, 32'h33};
        logic [31:0] sw [3] = '{32'hA1, 32'hB2, 32'hC3};
        logic [31:0] got [3];
        int base, rbase;
        set_sel(0);
        tx_push(sw[0]);
        base = rxq.size(); rbase = rdy_rises;
        fork
            begin
                ss_low();
                for (int k = 0; k < 3; k++) spi_word(mw[k], 8, got[k]);
                ss_high();
            end
            begin
                tx_push(sw[1]);
                tx_push(sw[2]);
            end
        join
        checks++; if (rxq.size() - base !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d required=3", rxq.size() - base); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rxq.size() < base + k + 1 || rxq[base + k] !== mw[k]) begin
                failures++; $display("FAIL b2b_rx%0d got=%h required=%h", k, (rxq.size() > base + k) ? rxq[base + k] : 32'hx, mw[k]);
            end
            checks++; if (got[k] !== sw[k]) begin failures++; $display("FAIL b2b_miso%0d got=%h required=%h", k, got[k], sw[k]); end
        end
        checks++; if (rdy_rises - rbase !== 3) begin failures++; $display("FAIL b2b_tx_ready_rises got=%0d required=3", rdy_rises - rbase); end
    endtask

    task automatic test_abort();
        logic [31:0] got;
        int base;
        set_sel(0);
        base = rxq.size();
        ss_low(); spi_word(32'h5A, 5, got); ss_high();
        checks++; if (rxq.size() - base !== 0) begin failures++; $display("FAIL abort_done got=%0d required=0", rxq.size() - base); end
        checks++; if (rx_data_sel !== 32'h33) begin failures++; $display("FAIL abort_rx_hold got=%h required=33", rx_data_sel); end
        checks++; if (busy_sel !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b required=0", busy_sel); end
        ss_low(); spi_word(32'h7E, 8, got); ss_high();
        checks++; if (rx_data_sel !== 32'h7E) begin failures++; $display("FAIL abort_next_rx got=%h required=7e", rx_data_sel); end
        checks++; if (rxq.size() - base !== 1) begin failures++; $display("FAIL abort_next_done got=%0d required=1", rxq.size() - base); end
    endtask

    task automatic test_overrun();
        logic [31:0] got;
        set_sel(0);
        rx_ack_pulse();
        ss_low(); spi_word(32'h12, 8, got); spi_word(32'h34, 8, got); ss_high();
        checks++; if (rx_data_sel !== 32'h34) begin failures++; $display("FAIL ovr_rx_data got=%h required=34", rx_data_sel); end
        checks++; if (rx_valid_sel !== 1'b1) begin failures++; $display("FAIL ovr_rx_valid got=%b required=1", rx_valid_sel); end
`ifdef SPI_SLAVE_N_OVERRUN_EN
        checks++; if (ovr_sel !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b required=1", ovr_sel); end
`endif
        tx_push(32'h99);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if ({tx_ready_sel, rx_valid_sel, ovr_sel} !== 3'b100) begin failures++; $display("FAIL ovr_after_rst got=%b required=100", {tx_ready_sel, rx_valid_sel, ovr_sel}); end
    endtask

    task automatic test_rst_mid16();
        logic [31:0] got;
        int base;
        set_sel(4);
        ss_low(); spi_word(32'h1357, 16, got); ss_high();
        checks++; if (rx_data_sel !== 32'h1357) begin failures++; $display("FAIL w16_first got=%h required=1357", rx_data_sel); end
        tx_push(32'hAAAA);
        ss_low();
        tx_push(32'h1111);
        spi_word(32'hFFFF, 6, got);
        checks++; if ({busy_sel, tx_ready_sel, rx_valid_sel} !== 3'b101) begin failures++; $display("FAIL w16_pre_rst got=%b required=101", {busy_sel, tx_ready_sel, rx_valid_sel}); end
        @(negedge clk); rst = 1'b1; m_ss = 1'b1; m_act = 1'b0;
        @(negedge clk);
        checks++; if ({busy_sel, tx_ready_sel, rx_valid_sel, done_sel, miso_sel, oe_sel} !== 6'b010000) begin
            failures++; $display("FAIL w16_rst_outputs got=%b required=010000", {busy_sel, tx_ready_sel, rx_valid_sel, done_sel, miso_sel, oe_sel});
        end
        checks++; if (rx_data_sel !== 32'h0) begin failures++; $display("FAIL w16_rst_rx_data got=%h required=0", rx_data_sel); end
        repeat (2) @(negedge clk); rst = 1'b0;
        repeat (6) @(negedge clk);
        base = rxq.size();
        tx_push(32'hC0DE);
        ss_low(); spi_word(32'hBEEF, 16, got); ss_high();
        checks++; if (rx_data_sel !== 32'hBEEF) begin failures++; $display("FAIL w16_beef got=%h required=beef", rx_data_sel); end
        checks++; if (got !== 32'hC0DE) begin failures++; $display("FAIL w16_miso got=%h required=c0de", got); end
        checks++; if (rxq.size() - base !== 1) begin failures++; $display("FAIL w16_done_count got=%0d required=1", rxq.size() - base); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes_lsb();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_rst_mid16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave_n.md
SPI_SLAVE_N -- requirements
Module: spi_slave_n

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits; legal range 4..32.
REQ-002 Parameter CPOL, default 0: sck idle level.
REQ-003 Parameter CPHA, default 0: 0 samples on the leading edge, 1 samples on the trailing edge.
REQ-004 Parameter MSB_FIRST, default 1: 1 shifts MSB first, 0 shifts LSB first.
REQ-005 Parameter SYNC_STAGES, default 2: synchroniser depth on ss, sck and mosi; legal range 2..3.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  system clock; all state is on its rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-007 Remaining ports SHALL be as follows:
- ss  in  1  slave select, active low, asynchronous to clk.
- sck  in  1  SPI clock, asynchronous; f_sck <= f_clk/8.
- mosi  in  1  serial data in.
- miso  out  1  serial data out.
- miso_oe  out  1  output enable; high while ss is synchronised low.
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register is empty.
- rx_data  out  DATA_W  last completed received word.
- rx_valid  out  1  rx_data is unread.
- rx_ack  in  1  consumer read rx_data.
- done  out  1  one-cycle pulse per completed word.
- busy  out  1  a frame is active.

Function
REQ-010 ss, sck and mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected from the synchronised values only.
REQ-011 The FSM SHALL have the states IDLE, LOAD and XFER.
- IDLE -> LOAD on synchronised ss falling.
- LOAD -> XFER after 1 cycle.
- XFER -> IDLE on synchronised ss rising.
REQ-012 Sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge is the other edge. Leading edge = transition away from CPOL.
REQ-013 On any tx_valid && tx_ready cycle, the block SHALL capture tx_data into the holding register, and tx_ready SHALL go low on the next cycle.
REQ-014 LOAD SHALL copy the holding register into the tx shift register and set tx_ready high; if the holding register is empty, the shift register SHALL load all zeros.
REQ-015 With CPHA=0, the first bit SHALL appear on miso by the end of LOAD; with CPHA=1, the first bit SHALL appear on the first shift edge.
REQ-016 The bit counter SHALL run 0..DATA_W-1 and advance on each sample edge; on the final bit it SHALL wrap to 0.
REQ-017 On the wrap cycle, the block SHALL:
- latch the rx shift register into rx_data;
- set rx_valid;
- pulse done for exactly 1 clk;
- reload the tx shift register from the holding register, as in REQ-014.
REQ-018 Back-to-back words within one ss-low frame SHALL be supported with no dead sck cycles.
REQ-019 rx_valid SHALL stay high until rx_ack is sampled high; if rx_ack coincides with a new done, rx_valid SHALL remain high with the new data.
REQ-020 ss rising mid-word SHALL discard the partial word, clear the counter, leave rx_data unchanged, and produce no done.
REQ-021 miso SHALL be 0 whenever miso_oe is low; busy SHALL equal (state != IDLE).
REQ-022 done SHALL assert on the clk cycle after the cycle in which the synchronised final sample edge is detected.

Reset
REQ-030 Reset SHALL apply only on a clk edge with rst high, and SHALL override all other activity.
REQ-031 Reset SHALL set the following values:
- state = IDLE;
- rx_data, the shift registers, the counter and the holding register = 0;
- rx_valid = done = busy = miso = miso_oe = 0;
- tx_ready = 1;
- synchroniser flops: ss = 1, sck = CPOL.
REQ-032 Reset during XFER SHALL abort the frame with no done pulse.

Configuration
REQ-040 When SPI_SLAVE_N_OVERRUN_EN is defined, the block SHALL add output `overrun` (1 bit). overrun SHALL be set when done fires while rx_valid is already high and rx_ack is low; it SHALL be sticky until rst; rx_data SHALL still take the new word.
REQ-041 Without SPI_SLAVE_N_OVERRUN_EN, the overrun port and its logic SHALL be absent, and the data-overwrite behaviour SHALL be unchanged.

Structure
REQ-050 Shared package spi_pkg SHALL hold the FSM state typedef (IDLE/LOAD/XFER) and the localparams for SYNC_STAGES and DATA_W limits.
REQ-051 The block SHALL use one sub-module, spi_sync_edge: an N-stage synchroniser plus a rise/fall pulse generator, instantiated for ss and sck; mosi uses the synchroniser only.

Verification
REQ-060 Mode 0, DATA_W=8: master sends 0xA5 with tx_data=0x3C preloaded -> rx_data=0xA5, one done pulse, master receives 0x3C.
REQ-061 Modes 1, 2 and 3, each with MSB_FIRST=0: 0x81 exchanged -> correct bit order both directions.
REQ-062 Three back-to-back words 0x11, 0x22, 0x33 in one ss-low frame, with tx refilled after each done -> 3 done pulses, rx sequence correct, tx_ready pulses high 3 times.
REQ-063 ss deasserted after 5 of 8 bits -> no done, rx_data holds its previous value; the next full frame with 0x7E -> rx_data=0x7E.
REQ-064 Two words with rx_ack never asserted, OVERRUN_EN defined -> overrun=1, rx_data = second word; after rst, overrun=0 and tx_ready=1.
REQ-065 rst asserted mid-XFER, DATA_W=16 -> all outputs reach their reset values on the next clk edge; a subsequent 0xBEEF frame is received correctly.
